// File: rtl/pipelined_rot_shift.sv
// Purpose    : pipelined N-bit barrel unit; ROTR / ROTL / SHR / SRA selected per word, tag carried alongside.
// Latency    : LAT = ceil(LOG2_N/REG_EVERY) cycles from accept to out_valid; one word per clock when not stalled.
// Backpressure: single global advance (out_ready || !out_valid); in_ready = advance, the whole pipe freezes on a stall.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      operand handshake; in_data (MSB-first word), in_amt (MSB weight N/2), in_mode, in_tag
//   out_valid/out_ready    result handshake; out_data, out_tag held stable while stalled
//   in_mode: 00 ROTR, 01 ROTL, 10 SHR (logical), 11 SRA (arithmetic)
module pipelined_rot_shift #(
    parameter int N         = 32,
    parameter int LOG2_N    = 5,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_data,
    input  logic [LOG2_N-1:0] in_amt,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int LAT = (LOG2_N + REG_EVERY - 1) / REG_EVERY;

    localparam logic [1:0] M_ROTR = 2'b00;
    localparam logic [1:0] M_ROTL = 2'b01;
    localparam logic [1:0] M_SHR  = 2'b10;

    // One mux stage. Numeric right shift moves MSB-first bit i to bit i+k.
    // SRA fills from the current MSB; earlier SRA stages never change the
    // MSB, so it is still the operand's original sign bit.
    function automatic logic [N-1:0] f_stage(input logic [N-1:0] d, input int k, input logic [1:0] m);
        logic [N-1:0] res;
        case (m)
            M_ROTR:  res = (d >> k) | (d << (N - k));
            M_ROTL:  res = (d << k) | (d >> (N - k));
            M_SHR:   res = d >> k;
            default: res = $signed(d) >>> k;
        endcase
        return res;
    endfunction

    logic              r_vld  [LAT];
    logic [N-1:0]      r_data [LAT];
    logic [LOG2_N-1:0] r_amt  [LAT];
    logic [1:0]        r_mode [LAT];
    logic [TAG_W-1:0]  r_tag  [LAT];

    logic              w_src_vld  [LAT];
    logic [N-1:0]      w_src_data [LAT];
    logic [LOG2_N-1:0] w_src_amt  [LAT];
    logic [1:0]        w_src_mode [LAT];
    logic [TAG_W-1:0]  w_src_tag  [LAT];
    logic [N-1:0]      w_nxt_data [LAT];
    logic              w_adv;

    assign w_adv     = out_ready || !out_valid;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[LAT-1];
    assign out_data  = r_data[LAT-1];
    assign out_tag   = r_tag[LAT-1];

    // Rank r sees either the input port or the previous rank, then applies
    // the mux stages s with s/REG_EVERY == r (the last rank may hold fewer).
    always_comb begin
        w_src_vld[0]  = in_valid;
        w_src_data[0] = in_data;
        w_src_amt[0]  = in_amt;
        w_src_mode[0] = in_mode;
        w_src_tag[0]  = in_tag;
        for (int r = 1; r < LAT; r++) begin
            w_src_vld[r]  = r_vld[r-1];
            w_src_data[r] = r_data[r-1];
            w_src_amt[r]  = r_amt[r-1];
            w_src_mode[r] = r_mode[r-1];
            w_src_tag[r]  = r_tag[r-1];
        end
        for (int r = 0; r < LAT; r++) begin
            w_nxt_data[r] = w_src_data[r];
            for (int s = 0; s < LOG2_N; s++) begin
                // amt is MSB-first: stage s (weight N>>(s+1)) reads bit LOG2_N-1-s
                if ((s / REG_EVERY) == r && w_src_amt[r][LOG2_N-1-s]) begin
                    w_nxt_data[r] = f_stage(w_nxt_data[r], N >> (s + 1), w_src_mode[r]);
                end
            end
        end
    end

    // Payload only loads behind a valid word: bubbles never disturb a rank,
    // so out_data/out_tag stay 0 until the first result and X inputs on idle
    // cycles never reach the registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < LAT; r++) begin
                r_vld[r]  <= 1'b0;
                r_data[r] <= '0;
                r_amt[r]  <= '0;
                r_mode[r] <= '0;
                r_tag[r]  <= '0;
            end
        end else if (w_adv) begin
            for (int r = 0; r < LAT; r++) begin
                r_vld[r] <= w_src_vld[r];
                if (w_src_vld[r]) begin
                    r_data[r] <= w_nxt_data[r];
                    r_amt[r]  <= w_src_amt[r];
                    r_mode[r] <= w_src_mode[r];
                    r_tag[r]  <= w_src_tag[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_rot_shift.sv
// Purpose    : bench for pipelined_rot_shift; main instance N=16/REG_EVERY=2 plus REG_EVERY=1, REG_EVERY=4 and N=32 sweeps.
// Latency    : expected latencies are the constants 2, 4, 1 and 5 for the four instances.
// Backpressure: main instance driven with steady and LFSR-toggled out_ready; sweep instances always ready.
module tb_pipelined_rot_shift;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic [3:0]  in_amt, in_tag, out_tag;
    logic [1:0]  in_mode;

    logic        s_in_valid;
    logic [31:0] s_in_data;
    logic [4:0]  s_in_amt;
    logic [1:0]  s_in_mode;
    logic [3:0]  s_in_tag;
    logic        s_out_ready;
    logic        a_rdy, a_vld, b_rdy, b_vld, c_rdy, c_vld;
    logic [15:0] a_dat, b_dat;
    logic [31:0] c_dat;
    logic [3:0]  a_tag, b_tag, c_tag;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_rot_shift #(.N(16), .LOG2_N(4), .REG_EVERY(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag));

    pipelined_rot_shift #(.N(16), .LOG2_N(4), .REG_EVERY(1), .TAG_W(4)) dut_r1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(a_rdy), .in_data(s_in_data[15:0]),
        .in_amt(s_in_amt[3:0]), .in_mode(s_in_mode), .in_tag(s_in_tag), .out_valid(a_vld),
        .out_ready(s_out_ready), .out_data(a_dat), .out_tag(a_tag));

    pipelined_rot_shift #(.N(16), .LOG2_N(4), .REG_EVERY(4), .TAG_W(4)) dut_r4 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(b_rdy), .in_data(s_in_data[15:0]),
        .in_amt(s_in_amt[3:0]), .in_mode(s_in_mode), .in_tag(s_in_tag), .out_valid(b_vld),
        .out_ready(s_out_ready), .out_data(b_dat), .out_tag(b_tag));

    pipelined_rot_shift #(.N(32), .LOG2_N(5), .REG_EVERY(1), .TAG_W(4)) dut_32 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(c_rdy), .in_data(s_in_data),
        .in_amt(s_in_amt), .in_mode(s_in_mode), .in_tag(s_in_tag), .out_valid(c_vld),
        .out_ready(s_out_ready), .out_data(c_dat), .out_tag(c_tag));

    typedef struct {
        logic [1:0]  m;
        logic [3:0]  a;
        logic [15:0] d;
        logic [3:0]  t;
        logic [15:0] e;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  t;
        int          c;
        bit          chk_lat;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        int          c;
        int          lat;
    } sexp_t;

    exp_t  sb[$];
    sexp_t q_a[$], q_b[$], q_c[$];
    vec_t  tbl[13];

    logic        lfsr_en = 1'b0;
    logic [7:0]  lfsr    = 8'hA5;
    bit          stalled = 1'b0;
    logic [15:0] held_d;
    logic [3:0]  held_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bit-by-bit reference with index 0 = MSB, written directly from the mode definitions.
    function automatic logic [31:0] ref_op(input int n, input logic [31:0] d, input int k, input logic [1:0] m);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < n; i++) begin
            logic b;
            case (m)
                2'b00:   b = d[n-1-((i - k + n) % n)];
                2'b01:   b = d[n-1-((i + k) % n)];
                2'b10:   b = (i < k) ? 1'b0 : d[n-1-(i-k)];
                default: b = (i < k) ? d[n-1] : d[n-1-(i-k)];
            endcase
            o[n-1-i] = b;
        end
        return o;
    endfunction

    task automatic send(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m,
                        input logic [3:0] t, input logic [15:0] e, input bit chk_lat);
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = d;
            in_amt   = a;
            in_mode  = m;
            in_tag   = t;
            #1;
            if (in_ready) begin
                sb.push_back('{d: e, t: t, c: cyc, chk_lat: chk_lat});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_data  = 16'hDEAD;
                break;
            end
            guard++;
            if (guard > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
                in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while ((sb.size() + q_a.size() + q_b.size() + q_c.size()) > 0 && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        chk({nm, "_drained"}, 32'(sb.size() + q_a.size() + q_b.size() + q_c.size()), 32'd0);
    endtask

    // out_ready pattern for the backpressure stream
    always @(negedge clk) begin
        if (lfsr_en) begin
            lfsr      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            out_ready = lfsr[0];
        end
    end

    // Main instance monitor: sampled mid-low-phase; a transfer happens at the
    // next rising edge when out_valid && out_ready are seen here.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            chk("in_ready_eq_adv", 32'(in_ready), 32'(out_ready || !out_valid));
            if (stalled) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(held_d));
                chk("hold_tag", 32'(out_tag), 32'(held_t));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got data %h tag %h, expected no word", out_data, out_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_tag", 32'(out_tag), 32'(e.t));
                    if (e.chk_lat) chk("latency", 32'(cyc - e.c), 32'd2);
                end
            end
            stalled = out_valid && !out_ready;
            held_d  = out_data;
            held_t  = out_tag;
        end
    end

    task automatic sweep_pop(input int k, input logic [31:0] d, input logic [3:0] t);
        sexp_t e;
        bit    have;
        have = 1'b0;
        case (k)
            0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
            1: if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sweep%0d_unexpected: got data %h, expected no word", k, d);
        end else begin
            chk($sformatf("sweep%0d_data", k), d, e.d);
            chk($sformatf("sweep%0d_tag", k), 32'(t), 32'(e.t));
            chk($sformatf("sweep%0d_latency", k), 32'(cyc - e.c), 32'(e.lat));
        end
    endtask

    always @(negedge clk) begin
        #3;
        if (!rst) begin
            if (a_vld) sweep_pop(0, 32'(a_dat), a_tag);
            if (b_vld) sweep_pop(1, 32'(b_dat), b_tag);
            if (c_vld) sweep_pop(2, c_dat, c_tag);
        end
    end

    initial begin
        tbl[0]  = '{m: 2'b00, a: 4'd1,  d: 16'h8001, t: 4'd3,  e: 16'hC000};
        tbl[1]  = '{m: 2'b01, a: 4'd4,  d: 16'h8001, t: 4'd1,  e: 16'h0018};
        tbl[2]  = '{m: 2'b11, a: 4'd3,  d: 16'h8000, t: 4'd2,  e: 16'hF000};
        tbl[3]  = '{m: 2'b10, a: 4'd15, d: 16'h8000, t: 4'd4,  e: 16'h0001};
        tbl[4]  = '{m: 2'b00, a: 4'd0,  d: 16'hA5C3, t: 4'd5,  e: 16'hA5C3};
        tbl[5]  = '{m: 2'b01, a: 4'd0,  d: 16'hA5C3, t: 4'd6,  e: 16'hA5C3};
        tbl[6]  = '{m: 2'b10, a: 4'd0,  d: 16'hA5C3, t: 4'd7,  e: 16'hA5C3};
        tbl[7]  = '{m: 2'b11, a: 4'd0,  d: 16'hA5C3, t: 4'd8,  e: 16'hA5C3};
        tbl[8]  = '{m: 2'b11, a: 4'd15, d: 16'h7FFF, t: 4'd9,  e: 16'h0000};
        tbl[9]  = '{m: 2'b00, a: 4'd15, d: 16'h0001, t: 4'd10, e: 16'h0002};
        tbl[10] = '{m: 2'b10, a: 4'd8,  d: 16'hFFFF, t: 4'd11, e: 16'h00FF};
        tbl[11] = '{m: 2'b11, a: 4'd8,  d: 16'h9000, t: 4'd12, e: 16'hFF90};
        tbl[12] = '{m: 2'b01, a: 4'd9,  d: 16'h1234, t: 4'd13, e: 16'h6824};

        rst = 1'b1;
        in_valid = 1'b0; in_data = 16'h0; in_amt = 4'h0; in_mode = 2'b00; in_tag = 4'h0;
        out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = 32'h0; s_in_amt = 5'h0; s_in_mode = 2'b00; s_in_tag = 4'h0;
        s_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_data = 16'hBEEF;
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_out_data", 32'(out_data), 32'd0);

        // single word, then the rest back to back with out_ready held high
        @(negedge clk);
        out_ready = 1'b1;
        send(tbl[0].d, tbl[0].a, tbl[0].m, tbl[0].t, tbl[0].e, 1'b1);
        drain("first_word");
        for (int i = 1; i < 13; i++) send(tbl[i].d, tbl[i].a, tbl[i].m, tbl[i].t, tbl[i].e, 1'b1);
        drain("table");

        // stream under LFSR backpressure, checked against the reference model
        lfsr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] d;
            logic [3:0]  a;
            logic [1:0]  m;
            d = 16'($urandom);
            a = 4'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 3));
            send(d, a, m, 4'(i), 16'(ref_op(16, 32'(d), int'(a), m)), 1'b0);
        end
        drain("lfsr_stream");
        @(negedge clk);
        lfsr_en = 1'b0;
        out_ready = 1'b0;

        // reset with two words in flight
        send(16'h1111, 4'd1, 2'b00, 4'd14, 16'h8888, 1'b0);
        send(16'h2222, 4'd2, 2'b01, 4'd15, 16'h8888, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_out_data", 32'(out_data), 32'd0);
        chk("midreset_out_tag", 32'(out_tag), 32'd0);
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        send(16'h00F0, 4'd4, 2'b10, 4'd6, 16'h000F, 1'b1);
        drain("post_reset");
        repeat (6) @(posedge clk);

        // exhaustive amt x mode on one random operand across the three sweep instances
        begin
            logic [31:0] opnd;
            opnd = $urandom;
            for (int idx = 0; idx < 128; idx++) begin
                logic [4:0] a;
                logic [1:0] m;
                a = 5'(idx % 32);
                m = 2'(idx / 32);
                @(negedge clk);
                #1;
                s_in_valid = 1'b1;
                s_in_data  = opnd;
                s_in_amt   = a;
                s_in_mode  = m;
                s_in_tag   = 4'(idx);
                q_a.push_back('{d: ref_op(16, {16'h0, opnd[15:0]}, int'(a[3:0]), m), t: 4'(idx), c: cyc, lat: 4});
                q_b.push_back('{d: ref_op(16, {16'h0, opnd[15:0]}, int'(a[3:0]), m), t: 4'(idx), c: cyc, lat: 1});
                q_c.push_back('{d: ref_op(32, opnd, int'(a), m), t: 4'(idx), c: cyc, lat: 5});
            end
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
        end
        drain("sweep");
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
